// File: rtl/rdyval_pkg.sv
// Shared sizing helpers and protocol-check macros for the rdy/val elastic chain.
`define RDYVAL_STABLE_UNDER_STALL(CLK, RSTN, CLR, V, R, D) \
  assert property (@(posedge CLK) disable iff (!(RSTN)) \
    ((V) && !(R) && !(CLR)) |=> ((CLR) || ((V) && $stable(D))))

package rdyval_pkg;

  function automatic int rdyval_cap(input int depth, input int skid);
    return depth * (1 + skid);
  endfunction

  function automatic int rdyval_cntw(input int depth, input int skid);
    return $clog2(rdyval_cap(depth, skid) + 1);
  endfunction

endpackage

// File: rtl/rdyval_elastic_stage.sv
// One elastic stage: a plain register with combinational ready (SKID=0) or a
// main+skid pair whose ready is a flop output (SKID=1).
module rdyval_elastic_stage
  import rdyval_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [DWIDTH-1:0] i_dat,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic [DWIDTH-1:0] o_dat
);

  logic              r_vld;
  logic [DWIDTH-1:0] r_dat;

  assign o_vld = r_vld;
  assign o_dat = r_dat;

  generate
    if (SKID == 0) begin : g_pipe
      logic w_up;

      assign o_rdy = ~r_vld | i_rdy;
      assign w_up  = i_vld & o_rdy;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_vld <= 1'b0;
        else if (i_flush) r_vld <= 1'b0;
        else if (w_up)    r_vld <= 1'b1;
        else if (i_rdy)   r_vld <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (w_up) r_dat <= i_dat;
      end
    end else begin : g_skid
      logic              r_sk_vld;
      logic [DWIDTH-1:0] r_sk_dat;
      logic              w_up;
      logic              w_dn;

      assign o_rdy = ~r_sk_vld;
      assign w_up  = i_vld & ~r_sk_vld;
      assign w_dn  = r_vld & i_rdy;

      // Skid only fills when main is occupied and not draining; it refills main first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld    <= 1'b0;
          r_sk_vld <= 1'b0;
        end else if (i_flush) begin
          r_vld    <= 1'b0;
          r_sk_vld <= 1'b0;
        end else if (r_sk_vld) begin
          if (w_dn) r_sk_vld <= 1'b0;
        end else if (w_up) begin
          if (!r_vld || w_dn) r_vld    <= 1'b1;
          else                r_sk_vld <= 1'b1;
        end else if (w_dn) begin
          r_vld <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (r_sk_vld) begin
          if (w_dn) r_dat <= r_sk_dat;
        end else if (w_up) begin
          if (!r_vld || w_dn) r_dat    <= i_dat;
          else                r_sk_dat <= i_dat;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rdyval_elastic_chain.sv
// DEPTH-stage rdy/val elastic pipeline with synchronous flush and occupancy count.
module rdyval_elastic_chain
  import rdyval_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2,
  parameter int SKID   = 0,
  parameter int CNTW   = rdyval_cntw(DEPTH, SKID)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  output logic              rdy,
  input  logic [DWIDTH-1:0] i_dat,
  output logic              vld_nxt,
  input  logic              rdy_nxt,
  output logic [DWIDTH-1:0] o_dat,
  input  logic              flush,
  output logic [CNTW-1:0]   count
);

  localparam int CAP = rdyval_cap(DEPTH, SKID);

  logic [DEPTH:0]             w_vld;
  logic [DEPTH:0]             w_rdy;
  logic [DEPTH:0][DWIDTH-1:0] w_dat;
  logic                       w_up;
  logic                       w_dn;
  logic [CNTW-1:0]            r_count;

  // Flush masks both chain ends so no word crosses the boundary in that cycle.
  assign w_vld[0]     = vld & ~flush;
  assign w_dat[0]     = i_dat;
  assign w_rdy[DEPTH] = rdy_nxt & ~flush;
  assign rdy          = w_rdy[0] & ~flush & rst_n;
  assign vld_nxt      = w_vld[DEPTH] & ~flush;
  assign o_dat        = w_dat[DEPTH];

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      rdyval_elastic_stage #(
        .DWIDTH(DWIDTH),
        .SKID  (SKID)
      ) u_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_flush(flush),
        .i_vld  (w_vld[g]),
        .o_rdy  (w_rdy[g]),
        .i_dat  (w_dat[g]),
        .o_vld  (w_vld[g+1]),
        .i_rdy  (w_rdy[g+1]),
        .o_dat  (w_dat[g+1])
      );
    end
  endgenerate

  assign w_up = vld & rdy;
  assign w_dn = vld_nxt & rdy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_count <= '0;
    else if (flush) r_count <= '0;
    else            r_count <= r_count + CNTW'(w_up) - CNTW'(w_dn);
  end

  assign count = r_count;

  `RDYVAL_STABLE_UNDER_STALL(clk, rst_n, flush, vld_nxt, rdy_nxt, o_dat);

  a_count_cap: assert property (@(posedge clk) disable iff (!rst_n) int'(r_count) <= CAP);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !((r_count == '0) && w_dn));

endmodule

// File: tb/tb_rdyval_elastic_chain.sv
// Bench: two chain configurations checked every cycle against a per-stage queue model.
module tb_rdyval_elastic_chain;

  logic             clk;
  logic             rst_n;
  logic [1:0]       s_vld, s_rdy, s_vn, s_rn, s_fl;
  logic [1:0][7:0]  s_dat, s_od;
  logic [1:0]       s_cnt0;
  logic [2:0]       s_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  // model: each stage is a small FIFO (cap 1 for SKID=0, cap 2 for SKID=1)
  int         mlen [2][3];
  logic [7:0] mq   [2][3][2];
  bit         pstall [2];
  logic [7:0] pod    [2];

  rdyval_elastic_chain #(.DWIDTH(8), .DEPTH(3), .SKID(0)) u_pipe (
    .clk(clk), .rst_n(rst_n), .vld(s_vld[0]), .rdy(s_rdy[0]), .i_dat(s_dat[0]),
    .vld_nxt(s_vn[0]), .rdy_nxt(s_rn[0]), .o_dat(s_od[0]), .flush(s_fl[0]), .count(s_cnt0)
  );

  rdyval_elastic_chain #(.DWIDTH(8), .DEPTH(2), .SKID(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .vld(s_vld[1]), .rdy(s_rdy[1]), .i_dat(s_dat[1]),
    .vld_nxt(s_vn[1]), .rdy_nxt(s_rn[1]), .o_dat(s_od[1]), .flush(s_fl[1]), .count(s_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic logic [3:0] readies(input int k);
    logic [3:0] r;
    int d;
    d = depth_of(k);
    r = '0;
    r[d] = s_rn[k] & ~s_fl[k];
    for (int i = d - 1; i >= 0; i--)
      r[i] = (k == 1) ? (mlen[k][i] < 2) : (mlen[k][i] == 0 || r[i+1]);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) mlen[k][i] = 0;
      pstall[k] = 1'b0;
    end
  endtask

  task automatic model_out(input int k, output bit e_rdy, output bit e_vn,
                           output logic [7:0] e_od, output int e_cnt);
    logic [3:0] r;
    int d;
    d = depth_of(k);
    r = readies(k);
    e_rdy = r[0] && !s_fl[k] && rst_n;
    e_vn  = (mlen[k][d-1] > 0) && !s_fl[k];
    e_od  = mq[k][d-1][0];
    e_cnt = 0;
    for (int i = 0; i < d; i++) e_cnt += mlen[k][i];
  endtask

  task automatic model_step(input int k);
    logic [3:0] r;
    int d;
    bit v;
    logic [7:0] x;
    d = depth_of(k);
    if (s_fl[k]) begin
      for (int i = 0; i < 3; i++) mlen[k][i] = 0;
      return;
    end
    r = readies(k);
    for (int b = d; b >= 0; b--) begin
      if (b == 0) begin v = s_vld[k]; x = s_dat[k]; end
      else begin v = (mlen[k][b-1] > 0); x = mq[k][b-1][0]; end
      if (v && r[b]) begin
        if (b < d) begin mq[k][b][mlen[k][b]] = x; mlen[k][b]++; end
        if (b > 0) begin mq[k][b-1][0] = mq[k][b-1][1]; mlen[k][b-1]--; end
      end
    end
  endtask

  task automatic check(input int k);
    bit e_rdy, e_vn;
    logic [7:0] e_od;
    int e_cnt, a_cnt;
    model_out(k, e_rdy, e_vn, e_od, e_cnt);
    a_cnt = (k == 0) ? int'(s_cnt0) : int'(s_cnt1);
    cmp($sformatf("rdy[%0d]", k), int'(s_rdy[k]), int'(e_rdy));
    cmp($sformatf("vld_nxt[%0d]", k), int'(s_vn[k]), int'(e_vn));
    cmp($sformatf("count[%0d]", k), a_cnt, e_cnt);
    if (e_vn) cmp($sformatf("o_dat[%0d]", k), int'(s_od[k]), int'(e_od));
    if (pstall[k] && !s_fl[k]) begin
      cmp($sformatf("stall_vld[%0d]", k), int'(s_vn[k]), 1);
      cmp($sformatf("stall_dat[%0d]", k), int'(s_od[k]), int'(pod[k]));
    end
    pstall[k] = e_vn && !s_rn[k];
    pod[k]    = e_od;
  endtask

  // inputs are set by the caller at the falling edge before calling tick
  task automatic tick();
    #1;
    check(0);
    check(1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_vld = '0; s_rn = '0; s_fl = '0; s_dat = '0;
  endtask

  task automatic clear_all();
    idle_inputs();
    s_fl = 2'b11;
    tick();
    s_fl = 2'b00;
  endtask

  initial begin
    int acc;
    bit a;
    bit acc_r [2];
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    cmp("reset_rdy0", int'(s_rdy[0]), 0);
    cmp("reset_rdy1", int'(s_rdy[1]), 0);
    cmp("reset_vn0", int'(s_vn[0]), 0);
    cmp("reset_vn1", int'(s_vn[1]), 0);
    cmp("reset_cnt1", int'(s_cnt1), 0);
    rst_n = 1'b1;
    #1;
    cmp("release_rdy0", int'(s_rdy[0]), 1);
    cmp("release_rdy1", int'(s_rdy[1]), 1);
    tick();

    // pipe: three back-to-back words, DEPTH-cycle latency
    clear_all();
    s_rn[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      s_vld[0] = (j < 3);
      s_dat[0] = 8'(j + 1);
      #1;
      if (j == 3) cmp("t1_count_peak", int'(s_cnt0), 3);
      if (j < 3) cmp("t1_vn_low", int'(s_vn[0]), 0);
      else begin
        cmp("t1_vn", int'(s_vn[0]), 1);
        cmp("t1_dat", int'(s_od[0]), j - 2);
      end
      tick();
    end

    // skid: fill with downstream stalled, then drain in order
    clear_all();
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      s_vld[1] = 1'b1;
      s_dat[1] = 8'(8'hA0 + acc);
      #1;
      a = s_rdy[1];
      tick();
      if (a) acc++;
    end
    cmp("t2_accepted", acc, 4);
    s_vld[1] = 1'b1;
    s_dat[1] = 8'hA4;
    #1;
    cmp("t2_rdy_full", int'(s_rdy[1]), 0);
    cmp("t2_count_full", int'(s_cnt1), 4);
    tick();
    s_vld[1] = 1'b0;
    s_rn[1]  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      cmp("t2_vn", int'(s_vn[1]), 1);
      cmp("t2_dat", int'(s_od[1]), 8'hA0 + j);
      tick();
    end

    // steady stream through the skid chain keeps count at 2
    clear_all();
    s_rn[1] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      s_vld[1] = 1'b1;
      s_dat[1] = 8'(8'h30 + j);
      #1;
      if (j >= 2) begin
        cmp("t6_count", int'(s_cnt1), 2);
        cmp("t6_dat", int'(s_od[1]), 8'h30 + j - 2);
      end
      tick();
    end

    // flush with two words held
    clear_all();
    for (int j = 0; j < 2; j++) begin
      s_vld[0] = 1'b1;
      s_dat[0] = 8'(8'h11 * (j + 1));
      tick();
    end
    s_vld[0] = 1'b1; s_dat[0] = 8'h33; s_rn[0] = 1'b1; s_fl[0] = 1'b1;
    #1;
    cmp("t4_flush_rdy", int'(s_rdy[0]), 0);
    cmp("t4_flush_vn", int'(s_vn[0]), 0);
    cmp("t4_flush_cnt_before", int'(s_cnt0), 2);
    tick();
    s_fl[0] = 1'b0; s_vld[0] = 1'b0;
    #1;
    cmp("t4_cnt_after", int'(s_cnt0), 0);
    cmp("t4_vn_after", int'(s_vn[0]), 0);
    repeat (4) tick();

    // asynchronous reset with the pipe full
    clear_all();
    for (int j = 0; j < 3; j++) begin
      s_vld[0] = 1'b1;
      s_dat[0] = 8'(8'h70 + j);
      tick();
    end
    s_vld[0] = 1'b0;
    #1;
    cmp("t5_cnt_pre", int'(s_cnt0), 3);
    rst_n = 1'b0;
    #1;
    cmp("t5_rst_vn", int'(s_vn[0]), 0);
    cmp("t5_rst_cnt", int'(s_cnt0), 0);
    cmp("t5_rst_rdy", int'(s_rdy[0]), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_rn[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      s_vld[0] = (j == 0);
      s_dat[0] = 8'h55;
      #1;
      if (j == 3) begin
        cmp("t5_new_vn", int'(s_vn[0]), 1);
        cmp("t5_new_dat", int'(s_od[0]), 8'h55);
      end else if (j < 3) begin
        cmp("t5_no_stale", int'(s_vn[0]), 0);
      end
      tick();
    end

    // random traffic on both chains, sources hold until accepted
    clear_all();
    acc_r[0] = 1'b1;
    acc_r[1] = 1'b1;
    for (int c = 0; c < 12000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (acc_r[k] || !s_vld[k]) begin
          s_vld[k] = ($urandom_range(0, 3) != 0);
          s_dat[k] = 8'($urandom);
        end
        s_rn[k] = $urandom_range(0, 1);
        s_fl[k] = ($urandom_range(0, 199) == 0);
      end
      #1;
      acc_r[0] = s_vld[0] & s_rdy[0];
      acc_r[1] = s_vld[1] & s_rdy[1];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rdyval_elastic_chain.md
Name: rdyval_elastic_chain

Overview:
Parametrised rdy/val pipeline of DEPTH register stages and DWIDTH data bits.
- Each stage is either a plain pipeline register (SKID=0) or a two-entry skid buffer (SKID=1). SKID=1 breaks the combinational ready path.
- Adds a synchronous flush and an occupancy count.
- Replaces hand-instantiated chains of fixed 32-bit stages between pull-side sources and push-side sinks.

Parameters:
DWIDTH, 32, data width in bits (>=1).
DEPTH, 2, number of stages (>=1).
SKID, 0, 0 = single-entry stages with combinational ready; 1 = two-entry stages with registered ready.
CNTW, $clog2(DEPTH*(1+SKID)+1), width of the occupancy count (derived; do not override).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
vld  input  1  upstream valid
rdy  output  1  upstream ready
i_dat  input  DWIDTH  upstream data
vld_nxt  output  1  downstream valid
rdy_nxt  input  1  downstream ready
o_dat  output  DWIDTH  downstream data
flush  input  1  synchronous discard of all held words
count  output  CNTW  number of words currently held

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). During reset and after release: all entries empty, vld_nxt=0, count=0. rdy=0 while rst_n=0. rdy=1 from the first cycle after release (flush=0). Data registers need not be reset; o_dat is don't-care while vld_nxt=0.
- Transfers: upstream transfer when vld&rdy; downstream transfer when vld_nxt&rdy_nxt.
- Ordering: strict FIFO, no loss, no duplication.
- Capacity: CAP=DEPTH*(1+SKID).
- Latency: a word accepted at edge t is presented on vld_nxt after edge t+DEPTH-1, i.e. DEPTH cycles through an empty chain, in both modes. The skid entry is bypassed when empty.
- Throughput: 1 word/cycle when rdy_nxt held high, both modes.
- Stage, SKID=0: rdy_i = ~full_i | rdy_nxt_i (combinational). The register loads on the upstream transfer and stays valid until the downstream transfer. Load and unload in the same cycle replace the content.
- Stage, SKID=1: holds main plus skid entry. rdy_i = ~skid_full_i (a flop output, no comb path from rdy_nxt).
  - main empty: incoming word goes to main.
  - main full and downstream not taking: incoming word goes to skid.
  - main leaving with skid full: skid moves to main, incoming word (possible only if skid was empty) is not accepted.
  - Data order is preserved.
- Stall: vld_nxt&~rdy_nxt holds o_dat and vld_nxt stable (rdy/val protocol rule; the bench asserts this).
- Upstream: once vld rises, the source holds vld/i_dat until rdy. The chain does not rely on this for correctness.
- Flush (flush=1 in a cycle):
  - rdy=0 and vld_nxt=0 combinationally, so no transfers occur that cycle.
  - At the edge all entries are cleared and count=0.
  - A multi-cycle flush keeps the chain empty.
  - Flush has priority over every other event.
- count: registered. count_next = count + up_xfer − dn_xfer; 0 on flush. Simultaneous up and down transfer leaves it unchanged. Never exceeds CAP, never underflows (assert).
- Full: count==CAP implies rdy=0 (SKID=1), or rdy=rdy_nxt (SKID=0).
- Empty: count==0 implies vld_nxt=0.
- Reset mid-operation: all held words discarded asynchronously. Outputs go to reset values immediately.

Decomposition:
- Package rdyval_pkg: function for CAP, CNTW helper, SVA-friendly protocol checks (stability property macros).
- Sub-module rdyval_elastic_stage (DWIDTH, SKID): one stage.
- Top: a generate loop of DEPTH stages plus the flush gating and the count register.
- Flush is distributed to every stage as a synchronous clear.

Test Plan:
1. DEPTH=3, SKID=0, rdy_nxt=1, send 0x1,0x2,0x3 back-to-back -> 0x1 on vld_nxt 3 cycles after acceptance, then 0x2, 0x3 on consecutive cycles; count peaks at 3.
2. DEPTH=2, SKID=1, rdy_nxt=0, vld=1 streaming 0xA0.. -> exactly 4 words accepted, rdy=0 afterwards, count=4. Release rdy_nxt -> 0xA0..0xA3 out in order, one per cycle, rdy recovers after 1 cycle.
3. SKID=1, random rdy_nxt (50%) and random vld, 10k words -> scoreboard: in-order, no loss/duplication. Formal/SVA: no comb path rdy_nxt->rdy, o_dat stable under stall.
4. DEPTH=2, SKID=0, 2 words held, flush=1 with vld=1 and rdy_nxt=1 -> no transfer that cycle, count=0 and vld_nxt=0 next cycle. The flushed words never appear.
5. rst_n asserted asynchronously mid-stream with count=3 -> vld_nxt=0 and count=0 immediately. After release, first new word 0x55 arrives after DEPTH cycles with no stale data.
6. Steady state with vld=1, rdy_nxt=1, count=2 -> count stays 2 every cycle, one word in and one out per cycle.
